// File: rtl/serial_frame_tx_if.sv
// Word-input handshake for serial_frame_tx: parallel word plus valid/ready.
// The master drives the word, the slave (serializer) returns in_ready.
interface serial_frame_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_len;

    modport master (output in_valid, output in_data, output in_len, input in_ready);
    modport slave  (input in_valid, input in_data, input in_len, output in_ready);
endinterface

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: serializes 4/8-bit words into start marker + MSB-first payload
// on the x_out/ser_out pair, with a one-word holding register for back-to-back frames.
// Optional macro SERIAL_FRAME_TX_PARITY_EN appends an even-parity bit to each frame.
module serial_frame_tx #(
    parameter int unsigned START_LEN = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rs,
    serial_frame_tx_if.slave     in_if,
    output logic                 x_out,
    output logic                 ser_out,
    output logic                 busy,
    output logic [CNT_W-1:0]     frame_cnt
);

`ifdef SERIAL_FRAME_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, START, DATA, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA} state_t;
`endif

    localparam logic [2:0] START_LAST = 3'(START_LEN - 1);

    state_t     state;
    logic [7:0] shift_q;
    logic       len_q;
    logic [2:0] cnt_q;
    logic [7:0] hold_data;
    logic       hold_len;
    logic       hold_full;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic       par_q;
`endif

    logic       accept;
    logic       frame_end;
    logic [2:0] last_idx;

    // 4-bit payloads are left-aligned so the shifter always emits from bit 7.
    function automatic logic [7:0] align(input logic [7:0] d, input logic l);
        return l ? d : {d[3:0], 4'b0000};
    endfunction

    assign in_if.in_ready = ~hold_full;

    // Handshake and end-of-frame detection.
    always_comb begin
        accept    = in_if.in_valid && !hold_full;
        last_idx  = len_q ? 3'd7 : 3'd3;
        frame_end = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        if (state == PARITY)
            frame_end = 1'b1;
`else
        if (state == DATA && cnt_q == last_idx)
            frame_end = 1'b1;
`endif
    end

    // Frame FSM, shifter, holding register and registered outputs.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            state     <= IDLE;
            shift_q   <= '0;
            len_q     <= 1'b0;
            cnt_q     <= '0;
            hold_data <= '0;
            hold_len  <= 1'b0;
            hold_full <= 1'b0;
            x_out     <= 1'b1;
            ser_out   <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            // Mid-frame arrivals park in the holding register; at a frame end an
            // arrival is only possible when the register is empty and goes straight in.
            if (accept && state != IDLE && !frame_end) begin
                hold_data <= in_if.in_data;
                hold_len  <= in_if.in_len;
                hold_full <= 1'b1;
            end

            if (frame_end) begin
                frame_cnt <= frame_cnt + 1'b1;
                cnt_q     <= '0;
                ser_out   <= 1'b0;
                if (hold_full) begin
                    shift_q   <= align(hold_data, hold_len);
                    len_q     <= hold_len;
                    hold_full <= 1'b0;
                    state     <= START;
                    x_out     <= 1'b0;
                end else if (accept) begin
                    shift_q <= align(in_if.in_data, in_if.in_len);
                    len_q   <= in_if.in_len;
                    state   <= START;
                    x_out   <= 1'b0;
                end else begin
                    state <= IDLE;
                    x_out <= 1'b1;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            shift_q <= align(in_if.in_data, in_if.in_len);
                            len_q   <= in_if.in_len;
                            cnt_q   <= '0;
                            state   <= START;
                            x_out   <= 1'b0;
                            ser_out <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                    START: begin
                        if (cnt_q == START_LAST) begin
                            state   <= DATA;
                            x_out   <= 1'b1;
                            ser_out <= shift_q[7];
                            shift_q <= {shift_q[6:0], 1'b0};
                            cnt_q   <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                            par_q   <= shift_q[7];
`endif
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                    DATA: begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        if (cnt_q == last_idx) begin
                            state   <= PARITY;
                            ser_out <= par_q;
                        end else begin
                            ser_out <= shift_q[7];
                            par_q   <= par_q ^ shift_q[7];
                            shift_q <= {shift_q[6:0], 1'b0};
                            cnt_q   <= cnt_q + 3'd1;
                        end
`else
                        ser_out <= shift_q[7];
                        shift_q <= {shift_q[6:0], 1'b0};
                        cnt_q   <= cnt_q + 3'd1;
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Testbench for serial_frame_tx: directed test-plan steps plus random traffic,
// checked cycle-by-cycle against an expected-stream model built from frame rules.
module tb_serial_frame_tx;
    localparam int unsigned SL = 2;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rs  = 1'b0;
    logic       x_out, ser_out, busy;
    logic [7:0] frame_cnt;

    always #5 clk = ~clk;

    serial_frame_tx_if bus ();

    serial_frame_tx #(.START_LEN(SL), .CNT_W(8)) dut (
        .clk       (clk),
        .rs        (rs),
        .in_if     (bus.slave),
        .x_out     (x_out),
        .ser_out   (ser_out),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Expected per-cycle output stream: {last_cycle_of_frame, x_out, ser_out}.
    logic [2:0] exp_q[$];
    int         pending   = 0;
    logic [7:0] completed = '0;
    logic       exp_ready = 1'b1;
    logic       accepted;
    logic [7:0] obs_bits = '0;
    int         busy_cycles = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_frame(input logic [7:0] d, input logic l);
        int         n   = l ? 8 : 4;
        logic [7:0] p   = l ? d : {4'b0000, d[3:0]};
        logic       par = 1'b0;
        for (int i = 0; i < int'(SL); i++) exp_q.push_back(3'b000);
        for (int i = n - 1; i >= 0; i--) begin
            par = par ^ p[i];
            exp_q.push_back({(i == 0 && PAR == 0), 1'b1, p[i]});
        end
        if (PAR != 0) exp_q.push_back({1'b1, 1'b1, par});
        pending++;
    endfunction

    task automatic tick();
        logic [2:0] e;
        logic       got;
        logic       ex, es, eb;
        @(posedge clk);
        if (rs && bus.in_valid && exp_ready) begin
            push_frame(bus.in_data, bus.in_len);
            accepted = 1'b1;
        end
        @(negedge clk);
        got = (exp_q.size() > 0);
        e   = got ? exp_q.pop_front() : 3'b010;
        ex  = e[1];
        es  = e[0];
        eb  = got;
        chk("x_out", {31'b0, x_out}, {31'b0, ex});
        chk("ser_out", {31'b0, ser_out}, {31'b0, es});
        chk("busy", {31'b0, busy}, {31'b0, eb});
        chk("in_ready", {31'b0, bus.in_ready}, {31'b0, (pending <= 1)});
        chk("frame_cnt", {24'b0, frame_cnt}, {24'b0, completed});
        exp_ready = (pending <= 1);
        if (busy) busy_cycles++;
        if (busy && x_out) obs_bits = {obs_bits[6:0], ser_out};
        if (got && e[2]) begin
            pending--;
            completed++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int k = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_len   = l;
        accepted     = 1'b0;
        while (!accepted && k < 100) begin
            tick();
            k++;
        end
        bus.in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout: observed not-accepted expected accepted");
        end
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() > 0 && k < 200) begin
            tick();
            k++;
        end
        tick();
    endtask

    task automatic model_reset();
        exp_q.delete();
        pending   = 0;
        completed = '0;
        exp_ready = 1'b1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_len   = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_x_out", {31'b0, x_out}, 32'd1);
        chk("rst_ser_out", {31'b0, ser_out}, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_frame_cnt", {24'b0, frame_cnt}, 32'd0);
        rs = 1'b1;
        idle(2);

        // Single 4-bit frames
`ifdef SERIAL_FRAME_TX_PARITY_EN
        send(8'h0B, 1'b0);
        drain();
        chk("par_1011_bits", {27'b0, obs_bits[4:0]}, {27'b0, 5'b10111});
        send(8'h09, 1'b0);
        drain();
        chk("par_1001_bits", {27'b0, obs_bits[4:0]}, {27'b0, 5'b10010});
        chk("frame_cnt_two", {24'b0, frame_cnt}, 32'd2);
`else
        send(8'h09, 1'b0);
        drain();
        chk("w1001_bits", {28'b0, obs_bits[3:0]}, {28'b0, 4'b1001});
        chk("frame_cnt_one", {24'b0, frame_cnt}, 32'd1);
`endif

        // 8-bit frame, busy duration
        busy_cycles = 0;
        send(8'h9D, 1'b1);
        drain();
        chk("busy_cycles_8b", busy_cycles, SL + 8 + PAR);
`ifndef SERIAL_FRAME_TX_PARITY_EN
        chk("w9D_bits", {24'b0, obs_bits}, {24'b0, 8'h9D});
`endif

        // Three words with valid held high (upper bits of 4-bit words are junk)
        send(8'hA5, 1'b0);
        send(8'h10, 1'b1);
        send(8'hEF, 1'b0);
        drain();

        // Reset during 3rd payload bit of an 8-bit frame with a word held
        send(8'hA5, 1'b1);
        send(8'h3C, 1'b1);
        idle(3);
        #2 rs = 1'b0;
        #1;
        chk("abort_x_out", {31'b0, x_out}, 32'd1);
        chk("abort_ser_out", {31'b0, ser_out}, 32'd0);
        chk("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_frame_cnt", {24'b0, frame_cnt}, 32'd0);
        model_reset();
        @(negedge clk);
        rs = 1'b1;
        idle(2);
        send(8'h06, 1'b0);
        drain();

        // Random traffic with random gaps
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 8)));
            send(8'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();

        // frame_cnt wrap
        #2 rs = 1'b0;
        #1 model_reset();
        @(negedge clk);
        rs = 1'b1;
        for (int i = 0; i < 255; i++) send(8'($urandom), 1'b0);
        drain();
        chk("frame_cnt_255", {24'b0, frame_cnt}, 32'd255);
        send(8'h5A, 1'b0);
        drain();
        chk("frame_cnt_wrap", {24'b0, frame_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
